mem_block_responder: RTL and testbench
======================================

Name: mem_block_responder

Overview:
- Memory-side responder for the cache's 128-bit block interface: mem_read/mem_write/mem_addr/mem_wdata in, mem_rdata/mem_ready out.
- Models main memory with a fixed, parameterised access latency and a synchronous 128-bit-wide backing array.
- Sits below the cache in simulation and FPGA builds; serves block fills and write-backs, and counts traffic for performance measurement.

Parameters:
- LATENCY, 4, cycles from request sampled in S_IDLE to the mem_ready cycle; legal range 1..255.
- IDX_W, 8, backing-array index width; depth = 2**IDX_W blocks of 128 bits.
- CNT_W, 32, width of the traffic counters.

Ports:
- clk  in  1  single clock; all logic on posedge.
- proc_reset  in  1  synchronous, active-high reset.
- mem_read  in  1  block read request; held by the cache until it samples mem_ready.
- mem_write  in  1  block write request; same hold rule.
- mem_addr  in  28  block address; only bits [IDX_W-1:0] index the array.
- mem_wdata  in  128  write data; valid while mem_write is high.
- mem_rdata  out  128  read data; valid only in the mem_ready cycle.
- mem_ready  out  1  one-cycle completion pulse.
- rd_count  out  CNT_W  number of completed reads.
- wr_count  out  CNT_W  number of completed writes.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset values: mem_ready=0, mem_rdata=0, rd_count=0, wr_count=0, proto_err=0, state=S_IDLE, latency counter=0. Array contents are not reset.
- States: S_IDLE, S_BUSY, S_RESP.
- S_IDLE, when mem_read|mem_write is high:
  - Latch op, idx=mem_addr[IDX_W-1:0], the full 28-bit address, and mem_wdata.
  - If LATENCY==1, go to S_RESP; otherwise load cnt=LATENCY-2 and go to S_BUSY.
- S_IDLE with no request: stay; mem_ready=0.
- S_BUSY: decrement cnt; when cnt==0, go to S_RESP on the next edge.
  - Write op: the array write commits on that same edge.
  - Read op: array data is loaded into the mem_rdata register on that same edge.
- S_RESP: mem_ready=1 for exactly one cycle, then S_IDLE unconditionally.
  - mem_rdata holds read data; it is 0 for a write response.
  - rd_count or wr_count increments on the edge leaving S_RESP; counters wrap at 2**CNT_W.
- Latency: request first high in cycle t gives mem_ready high in cycle t+LATENCY.
- Back-to-back requests: the cache changes its request on the edge that samples mem_ready. The new request is therefore visible in the first S_IDLE cycle after S_RESP, and is accepted there. No idle gap beyond that one cycle.
- mem_read and mem_write both high in S_IDLE: treat as write, set proto_err.
- In S_BUSY, if both requests are low, or mem_addr differs from the latched address, set proto_err. Service continues on latched values.
- Read-after-write to the same idx returns the newly written data.
- mem_rdata outside S_RESP: driven to 0.
- proto_err clears only on proc_reset.
- proc_reset mid-operation: abort immediately. A write not yet committed (still in S_BUSY) is discarded. A write committed on entry to S_RESP persists.

Decomposition:
- Shared package mem_if_pkg:
  - BLK_W=128, ADDR_W=28.
  - State encodings S_IDLE/S_BUSY/S_RESP.
  - Op encoding OP_RD/OP_WR.
- Sub-module mem_block_array: single-port synchronous 2**IDX_W x 128 array with write enable, index and registered read. It is the natural BRAM-inference boundary.
- FSM, latency counter, traffic counters and checks stay in mem_block_responder.

Test Plan:
1. Write then read:
   - Stimulus, LATENCY=4: write mem_addr=28'h0000012, mem_wdata=128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0, then read 28'h0000012.
   - Response: each mem_ready lands 4 cycles after its request. Read mem_rdata equals the written value. wr_count=1, rd_count=1.
2. Back-to-back chain:
   - Stimulus: cache-style write-back to 28'h0000105 immediately followed by a read of 28'h0000005 (same idx 0x05 with IDX_W=8).
   - Response: the read returns the write-back data. Second mem_ready lands exactly LATENCY+1 cycles after the first. proto_err=0.
3. LATENCY=1:
   - Stimulus: continuous reads of 3 consecutive addresses.
   - Response: mem_ready high every second cycle, with correct data each time.
4. Both requests high:
   - Stimulus: mem_read=mem_write=1, addr 28'h0000020, wdata 128'h1.
   - Response: treated as a write. proto_err=1 and stays 1. A subsequent read of 28'h0000020 returns 128'h1.
5. Reset mid-write:
   - Stimulus: write 128'hAAAA to idx 0x30 (old value 128'h5555). Assert proc_reset in the second S_BUSY cycle.
   - Response: mem_ready is never pulsed and the counters reset. A later read of idx 0x30 returns 128'h5555.
6. Request withdrawn:
   - Stimulus: mem_read drops during S_BUSY.
   - Response: the mem_ready pulse still occurs on schedule, and proto_err sets.

Source files
------------

// File: rtl/mem_if_pkg.sv
// Shared definitions for the 128-bit cache/memory block interface.
package mem_if_pkg;

    localparam int BLK_W  = 128;
    localparam int ADDR_W = 28;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

endpackage

// File: rtl/mem_block_array.sv
// Single-port synchronous block store; kept separate so it maps onto block RAM.
module mem_block_array #(
    parameter int IDX_W = 8,
    parameter int W     = 128
) (
    input  logic             clk,
    input  logic             we,
    input  logic             re,
    input  logic [IDX_W-1:0] idx,
    input  logic [W-1:0]     wdata,
    output logic [W-1:0]     rdata
);

    logic [W-1:0] mem [2**IDX_W];

    always_ff @(posedge clk) begin
        if (we)
            mem[idx] <= wdata;
        if (re)
            rdata <= mem[idx];
    end

endmodule

// File: rtl/mem_block_responder.sv
// Fixed-latency main-memory model answering block fills and write-backs,
// with traffic counters and a sticky protocol-violation flag.
module mem_block_responder
    import mem_if_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int IDX_W   = 8,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [BLK_W-1:0]  mem_wdata,
    output logic [BLK_W-1:0]  mem_rdata,
    output logic              mem_ready,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count,
    output logic              proto_err
);

    localparam logic [7:0] CNT_INIT = (LATENCY > 1) ? 8'(LATENCY - 2) : 8'd0;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t             state;
    state_t             next_state;
    logic [7:0]         cnt;
    op_t                op_q;
    op_t                req_op;
    op_t                arr_op;
    logic [IDX_W-1:0]   idx_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [BLK_W-1:0]   wdata_q;
    logic               req;
    logic               commit;
    logic               arr_we;
    logic               arr_re;
    logic [IDX_W-1:0]   arr_idx;
    logic [BLK_W-1:0]   arr_wdata;
    logic [BLK_W-1:0]   arr_rdata;

    assign req    = mem_read | mem_write;
    assign req_op = mem_write ? OP_WR : OP_RD;

    always_ff @(posedge clk) begin
        if (proc_reset)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (req) next_state = (LATENCY == 1) ? S_RESP : S_BUSY;
            S_BUSY: if (cnt == 8'd0) next_state = S_RESP;
            S_RESP: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // With LATENCY==1 the access happens straight from the live request lines.
    always_comb begin
        mem_ready = (state == S_RESP);
        mem_rdata = (state == S_RESP && op_q == OP_RD) ? arr_rdata : '0;
        commit    = (state == S_BUSY && cnt == 8'd0) ||
                    (state == S_IDLE && req && LATENCY == 1);
        arr_idx   = (state == S_IDLE) ? mem_addr[IDX_W-1:0] : idx_q;
        arr_wdata = (state == S_IDLE) ? mem_wdata : wdata_q;
        arr_op    = (state == S_IDLE) ? req_op : op_q;
        arr_we    = commit && (arr_op == OP_WR);
        arr_re    = commit && (arr_op == OP_RD);
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            cnt       <= 8'd0;
            rd_count  <= '0;
            wr_count  <= '0;
            proto_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        op_q    <= req_op;
                        idx_q   <= mem_addr[IDX_W-1:0];
                        addr_q  <= mem_addr;
                        wdata_q <= mem_wdata;
                        cnt     <= CNT_INIT;
                        if (mem_read && mem_write)
                            proto_err <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (cnt != 8'd0)
                        cnt <= cnt - 8'd1;
                    if (!req || mem_addr != addr_q)
                        proto_err <= 1'b1;
                end
                S_RESP: begin
                    if (op_q == OP_WR)
                        wr_count <= wr_count + CNT_ONE;
                    else
                        rd_count <= rd_count + CNT_ONE;
                end
                default: ;
            endcase
        end
    end

    mem_block_array #(
        .IDX_W (IDX_W),
        .W     (BLK_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .re    (arr_re),
        .idx   (arr_idx),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_mem_block_responder.sv
// Bench: a LATENCY=4 and a LATENCY=1 responder checked against a block-store model.
module tb_mem_block_responder;

    logic         clk = 1'b0;
    logic         rst  [2];
    logic         rd   [2];
    logic         wr   [2];
    logic         rdy  [2];
    logic         perr [2];
    logic [27:0]  addr [2];
    logic [127:0] wd   [2];
    logic [127:0] rdat [2];
    logic [31:0]  rdc  [2];
    logic [31:0]  wrc  [2];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int exp_rd [2];
    int exp_wr [2];
    logic [127:0] model_mem [int];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_block_responder #(.LATENCY(4), .IDX_W(8), .CNT_W(32)) u_dut (
        .clk(clk), .proc_reset(rst[0]), .mem_read(rd[0]), .mem_write(wr[0]),
        .mem_addr(addr[0]), .mem_wdata(wd[0]), .mem_rdata(rdat[0]),
        .mem_ready(rdy[0]), .rd_count(rdc[0]), .wr_count(wrc[0]),
        .proto_err(perr[0])
    );

    mem_block_responder #(.LATENCY(1), .IDX_W(8), .CNT_W(32)) u_dut1 (
        .clk(clk), .proc_reset(rst[1]), .mem_read(rd[1]), .mem_write(wr[1]),
        .mem_addr(addr[1]), .mem_wdata(wd[1]), .mem_rdata(rdat[1]),
        .mem_ready(rdy[1]), .rd_count(rdc[1]), .wr_count(wrc[1]),
        .proto_err(perr[1])
    );

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic resetDut(input int d);
        rst[d] = 1'b1;
        rd[d]  = 1'b0;
        wr[d]  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst[d] = 1'b0;
        exp_rd[d] = 0;
        exp_wr[d] = 0;
    endtask

    // One cache transaction, entered and left at posedge+1; the request is
    // withdrawn in cycle drop_at when non-zero.
    task automatic applyStimulus(input int d, input bit do_rd, input bit do_wr,
                                 input logic [27:0] a, input logic [127:0] data,
                                 input int drop_at, output int rcyc);
        int           key;
        int           lat;
        int           exp_lat;
        logic [127:0] got;
        logic [127:0] exp_data;
        key = d * 256 + int'(a[7:0]);
        rd[d] = do_rd;
        wr[d] = do_wr;
        addr[d] = a;
        wd[d] = data;
        lat = 0;
        rcyc = 0;
        got = '0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (rdy[d]) begin
                lat = k;
                rcyc = cyc;
                got = rdat[d];
                break;
            end
            if (drop_at == k) begin
                rd[d] = 1'b0;
                wr[d] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        rd[d] = 1'b0;
        wr[d] = 1'b0;
        if (do_wr) begin
            exp_data = '0;
            model_mem[key] = data;
            exp_wr[d]++;
        end else begin
            exp_data = model_mem[key];
            exp_rd[d]++;
        end
        exp_lat = (d == 0) ? 4 : 1;
        checkOutput("latency", 128'(lat), 128'(exp_lat));
        checkOutput("rdata", got, exp_data);
        checkOutput("ready_one_cycle", 128'(rdy[d]), 128'(0));
        checkOutput("rd_count", 128'(rdc[d]), 128'(exp_rd[d]));
        checkOutput("wr_count", 128'(wrc[d]), 128'(exp_wr[d]));
    endtask

    initial begin
        int           r1;
        int           r2;
        int           key;
        bit           do_wr;
        logic [7:0]   idx;
        logic [127:0] data;

        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; rd[i] = 1'b0; wr[i] = 1'b0;
            addr[i] = '0; wd[i] = '0;
            exp_rd[i] = 0; exp_wr[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        checkOutput("reset_ready", 128'(rdy[0]), 128'(0));
        checkOutput("reset_rdata", rdat[0], '0);
        checkOutput("reset_rd_count", 128'(rdc[0]), 128'(0));
        checkOutput("reset_wr_count", 128'(wrc[0]), 128'(0));
        checkOutput("reset_proto_err", 128'(perr[0]), 128'(0));

        $display("[TB] write then read");
        applyStimulus(0, 1'b0, 1'b1, 28'h0000012, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_F0F0, 0, r1);
        applyStimulus(0, 1'b1, 1'b0, 28'h0000012, '0, 0, r1);

        $display("[TB] back-to-back write-back and fill");
        applyStimulus(0, 1'b0, 1'b1, 28'h0000105, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 0, r1);
        applyStimulus(0, 1'b1, 1'b0, 28'h0000005, '0, 0, r2);
        checkOutput("b2b_gap", 128'(r2 - r1), 128'(5));
        checkOutput("b2b_proto_err", 128'(perr[0]), 128'(0));

        $display("[TB] random traffic");
        for (int i = 0; i < 24; i++) begin
            idx = 8'(8'h40 + $urandom_range(0, 11));
            key = int'(idx);
            do_wr = ($urandom_range(0, 1) == 1) || !model_mem.exists(key);
            data = {$urandom, $urandom, $urandom, $urandom};
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            applyStimulus(0, !do_wr, do_wr, {20'($urandom), idx}, data, 0, r1);
        end
        checkOutput("random_proto_err", 128'(perr[0]), 128'(0));

        $display("[TB] request withdrawn during busy");
        applyStimulus(0, 1'b1, 1'b0, 28'h0000012, '0, 2, r1);
        checkOutput("withdraw_proto_err", 128'(perr[0]), 128'(1));

        resetDut(0);
        checkOutput("rereset_proto_err", 128'(perr[0]), 128'(0));

        $display("[TB] both requests high");
        applyStimulus(0, 1'b1, 1'b1, 28'h0000020, 128'h1, 0, r1);
        checkOutput("both_proto_err", 128'(perr[0]), 128'(1));
        applyStimulus(0, 1'b1, 1'b0, 28'h0000020, '0, 0, r1);
        checkOutput("both_proto_err_sticky", 128'(perr[0]), 128'(1));

        $display("[TB] reset during write");
        applyStimulus(0, 1'b0, 1'b1, 28'h0000030, 128'h5555, 0, r1);
        rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 28'h0000030; wd[0] = 128'hAAAA;
        @(posedge clk);
        #1;
        checkOutput("abort_ready_busy1", 128'(rdy[0]), 128'(0));
        @(posedge clk);
        #1;
        rst[0] = 1'b1;
        wr[0] = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort_ready_in_reset", 128'(rdy[0]), 128'(0));
        rst[0] = 1'b0;
        exp_rd[0] = 0;
        exp_wr[0] = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            checkOutput("abort_no_ready", 128'(rdy[0]), 128'(0));
        end
        checkOutput("abort_wr_count", 128'(wrc[0]), 128'(0));
        checkOutput("abort_proto_err", 128'(perr[0]), 128'(0));
        applyStimulus(0, 1'b1, 1'b0, 28'h0000030, '0, 0, r1);

        $display("[TB] single-cycle latency streaming");
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 1'b0, 1'b1, 28'(28'h0000A40 + i), {4{$urandom}}, 0, r1);
        applyStimulus(1, 1'b1, 1'b0, 28'h0000A40, '0, 0, r1);
        for (int i = 1; i < 3; i++) begin
            applyStimulus(1, 1'b1, 1'b0, 28'(28'h0000A40 + i), '0, 0, r2);
            checkOutput("lat1_gap", 128'(r2 - r1), 128'(2));
            r1 = r2;
        end
        checkOutput("lat1_proto_err", 128'(perr[1]), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
